// File: rtl/ethernet_hdr_inserter_64bit_pkg.sv
// Shared definitions for the Ethernet header inserter: FSM states, header geometry
// and the IOQ module-header field layout with its length fix-up helper.
package ethernet_hdr_inserter_64bit_pkg;

  typedef enum logic [1:0] {
    HDR_PASS  = 2'd0,
    EMIT_HELD = 2'd1,
    PAYLOAD   = 2'd2,
    FLUSH     = 2'd3
  } ins_state_t;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int ETH_ALIGN_SHIFT = 6;

  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
  localparam int IOQ_BYTE_LEN_POS = 0;
  localparam int IOQ_SRC_PORT_POS = 16;
  localparam int IOQ_WORD_LEN_POS = 32;
  localparam int IOQ_DST_PORT_POS = 48;

  // Grow the byte length by the prepended header and recompute the word count from it.
  function automatic logic [63:0] ioq_len_fixup(input logic [63:0] w);
    logic [15:0] new_len;
    logic [16:0] word_sum;
    logic [63:0] r;
    new_len  = w[IOQ_BYTE_LEN_POS +: 16] + 16'(ETH_HDR_BYTES);
    word_sum = {1'b0, new_len} + 17'd7;
    r        = w;
    r[IOQ_BYTE_LEN_POS +: 16] = new_len;
    r[IOQ_WORD_LEN_POS +: 16] = 16'(word_sum >> 3);
    return r;
  endfunction

endpackage

// File: rtl/ethernet_hdr_inserter_64bit_if.sv
// 64-bit data/ctrl write/ready packet bus; the master drives words, the slave
// returns ready.
interface ethernet_hdr_inserter_64bit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, output ctrl, output wr, input rdy);
  modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/ethernet_hdr_inserter_64bit_codec.sv
// Combinational EOP ctrl codec: one-hot ctrl to valid byte count (0 when not one-hot)
// and byte count (1..8) back to one-hot ctrl (0 when out of range).
module eth_ctrl_byte_codec (
  input  logic [7:0] ctrl,
  output logic [3:0] byte_count,
  input  logic [3:0] count,
  output logic [7:0] onehot
);

  logic [7:0] match;

  for (genvar gi = 0; gi < 8; gi++) begin : g_match
    assign match[gi] = (ctrl == (8'h80 >> gi));
  end

  always_comb begin
    byte_count = '0;
    for (int i = 0; i < 8; i++) begin
      if (match[i]) byte_count = 4'(i + 1);
    end
  end

  always_comb begin
    onehot = '0;
    if (count >= 4'd1 && count <= 4'd8) onehot = 8'h80 >> (count - 4'd1);
  end

endmodule

// File: rtl/ethernet_hdr_inserter_64bit.sv
// Prepends a 14-byte Ethernet header to each packet and realigns the payload by 6 bytes.
// Define ETH_HDR_INS_LEN_FIXUP_EN to rewrite the IOQ header length fields on the way through.
module ethernet_hdr_inserter_64bit
  import ethernet_hdr_inserter_64bit_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_IQ_BITS = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  ethernet_hdr_inserter_64bit_if.slave         in_bus,
  ethernet_hdr_inserter_64bit_if.master        out_bus,
  input  logic [47:0]                          dst_mac,
  input  logic [47:0]                          src_mac,
  input  logic [15:0]                          ethertype
);

  localparam int CARRY_W = 8 * ETH_ALIGN_SHIFT;
  localparam int TAIL_W  = DATA_WIDTH - CARRY_W;

  ins_state_t            state_reg;
  logic [CARRY_W-1:0]    carry_reg;
  logic [DATA_WIDTH-1:0] hold_data_reg;
  logic [CTRL_WIDTH-1:0] hold_ctrl_reg;
  logic [3:0]            flush_bytes_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [CTRL_WIDTH-1:0] out_ctrl_reg;
  logic                  out_wr_reg;

  logic                  in_rdy;
  logic                  accept;
  logic [DATA_WIDTH-1:0] word_data;
  logic [CTRL_WIDTH-1:0] word_ctrl;
  logic [3:0]            word_bytes;
  logic [3:0]            enc_count;
  logic [7:0]            enc_ctrl;
  logic                  take_word;
  logic                  hdr_word;
  logic                  first_word;
  logic [DATA_WIDTH-1:0] pass_data;
  logic [NUM_IQ_BITS-1:0] unused_src_port;

  assign in_rdy     = !reset && out_bus.rdy && (state_reg == HDR_PASS || state_reg == PAYLOAD);
  assign in_bus.rdy = in_rdy;
  assign accept     = in_bus.wr && in_rdy;

  // The stashed first word is consumed from EMIT_HELD; every other data word comes live.
  assign word_data = (state_reg == EMIT_HELD) ? hold_data_reg : in_bus.data;
  assign word_ctrl = (state_reg == EMIT_HELD) ? hold_ctrl_reg : in_bus.ctrl;
  assign enc_count = (state_reg == FLUSH) ? flush_bytes_reg - 4'd2 : word_bytes + 4'd6;

  eth_ctrl_byte_codec u_codec (
    .ctrl       (word_ctrl),
    .byte_count (word_bytes),
    .count      (enc_count),
    .onehot     (enc_ctrl)
  );

  // Between packets a one-hot ctrl is the lone data word of a single-word packet;
  // any other nonzero ctrl is a module header.
  assign hdr_word   = (state_reg == HDR_PASS) && accept && (word_ctrl != '0) && (word_bytes == 4'd0);
  assign first_word = (state_reg == HDR_PASS) && accept && !hdr_word;
  assign take_word  = (state_reg == EMIT_HELD && out_bus.rdy) || (state_reg == PAYLOAD && accept);

  assign unused_src_port = in_bus.data[IOQ_SRC_PORT_POS +: NUM_IQ_BITS];

`ifdef ETH_HDR_INS_LEN_FIXUP_EN
  assign pass_data = (in_bus.ctrl == IO_QUEUE_STAGE_NUM) ? ioq_len_fixup(in_bus.data) : in_bus.data;
`else
  assign pass_data = in_bus.data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= HDR_PASS;
      carry_reg       <= '0;
      hold_data_reg   <= '0;
      hold_ctrl_reg   <= '0;
      flush_bytes_reg <= '0;
      out_data_reg    <= '0;
      out_ctrl_reg    <= '0;
      out_wr_reg      <= 1'b0;
    end else begin
      out_wr_reg <= 1'b0;
      if (hdr_word) begin
        out_data_reg <= pass_data;
        out_ctrl_reg <= in_bus.ctrl;
        out_wr_reg   <= 1'b1;
      end else if (first_word) begin
        out_data_reg  <= {dst_mac, src_mac[47:32]};
        out_ctrl_reg  <= '0;
        out_wr_reg    <= 1'b1;
        carry_reg     <= {src_mac[31:0], ethertype};
        hold_data_reg <= in_bus.data;
        hold_ctrl_reg <= in_bus.ctrl;
        state_reg     <= EMIT_HELD;
      end else if (take_word) begin
        out_data_reg <= {carry_reg, word_data[DATA_WIDTH-1 -: TAIL_W]};
        out_wr_reg   <= 1'b1;
        carry_reg    <= word_data[CARRY_W-1:0];
        if (word_bytes == 4'd0) begin
          out_ctrl_reg <= '0;
          state_reg    <= PAYLOAD;
        end else if (word_bytes <= 4'd2) begin
          out_ctrl_reg <= enc_ctrl;
          state_reg    <= HDR_PASS;
        end else begin
          // Tail bytes spill past this word; they leave with the carry next cycle.
          out_ctrl_reg    <= '0;
          flush_bytes_reg <= word_bytes;
          state_reg       <= FLUSH;
        end
      end else if (state_reg == FLUSH && out_bus.rdy) begin
        out_data_reg <= {carry_reg, {TAIL_W{1'b0}}};
        out_ctrl_reg <= enc_ctrl;
        out_wr_reg   <= 1'b1;
        state_reg    <= HDR_PASS;
      end
    end
  end

  assign out_bus.data = out_data_reg;
  assign out_bus.ctrl = out_ctrl_reg;
  assign out_bus.wr   = out_wr_reg;

endmodule

// File: tb/tb_ethernet_hdr_inserter_64bit.sv
// Randomized bench for ethernet_hdr_inserter_64bit against a byte-stream reference model.
module tb_ethernet_hdr_inserter_64bit;

  localparam logic [7:0] IOQ_CTRL = 8'hFF;
  localparam int WAIT_LIMIT = 400;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;

  ethernet_hdr_inserter_64bit_if in_bus ();
  ethernet_hdr_inserter_64bit_if out_bus ();

  word_t exp_q[$];
  word_t act_q[$];
  int    total = 0;
  int    bad = 0;
  int    rdy_violations = 0;
  logic  prev_rdy = 1'b1;
  bit    stall_mode = 1'b0;
  logic  rdy_toggle = 1'b1;

  always #5 clk = ~clk;

  assign out_bus.rdy = stall_mode ? rdy_toggle : 1'b1;

  always @(posedge clk) begin
    #1;
    rdy_toggle = ~rdy_toggle;
  end

  ethernet_hdr_inserter_64bit dut (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (in_bus),
    .out_bus   (out_bus),
    .dst_mac   (dst_mac),
    .src_mac   (src_mac),
    .ethertype (ethertype)
  );

  // Output monitor; an output word must follow a cycle in which out_rdy was high.
  always @(negedge clk) begin
    if (out_bus.wr === 1'b1) begin
      act_q.push_back(word_t'{out_bus.data, out_bus.ctrl});
      if (prev_rdy !== 1'b1) rdy_violations++;
    end
    prev_rdy = out_bus.rdy;
  end

  function automatic logic [63:0] valid_mask(input logic [7:0] c);
    logic [63:0] m;
    m = {64{1'b1}};
    for (int k = 1; k <= 8; k++)
      if (c == (8'h80 >> (k - 1))) m = ~({64{1'b1}} >> (8 * k));
    return m;
  endfunction

  function automatic logic [63:0] make_ioq(input int n);
    return {16'h0002, 16'((n + 7) / 8), 16'h0001, 16'(n)};
  endfunction

  // Reference: output = module header, then the byte stream dst|src|type|payload cut into words.
  task automatic model_packet(input bit with_ioq, input logic [7:0] pay[$]);
    logic [7:0]  ob[$];
    logic [63:0] d;
    int n, k;
    n = pay.size();
    if (with_ioq) begin
`ifdef ETH_HDR_INS_LEN_FIXUP_EN
      exp_q.push_back(word_t'{{16'h0002, 16'((n + 21) / 8), 16'h0001, 16'(n + 14)}, IOQ_CTRL});
`else
      exp_q.push_back(word_t'{make_ioq(n), IOQ_CTRL});
`endif
    end
    for (int i = 0; i < 6; i++) ob.push_back(dst_mac[47 - 8 * i -: 8]);
    for (int i = 0; i < 6; i++) ob.push_back(src_mac[47 - 8 * i -: 8]);
    ob.push_back(ethertype[15:8]);
    ob.push_back(ethertype[7:0]);
    foreach (pay[i]) ob.push_back(pay[i]);
    for (int w = 0; 8 * w < ob.size(); w++) begin
      d = '0;
      k = (ob.size() - 8 * w > 8) ? 8 : ob.size() - 8 * w;
      for (int j = 0; j < k; j++) d[63 - 8 * j -: 8] = ob[8 * w + j];
      exp_q.push_back(word_t'{d, (8 * w + k == ob.size()) ? (8'h80 >> (k - 1)) : 8'h00});
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    int cnt;
    in_bus.data = d;
    in_bus.ctrl = c;
    cnt = 0;
    @(negedge clk);
    while (in_bus.rdy !== 1'b1 && cnt < WAIT_LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt >= WAIT_LIMIT) begin
      bad++;
      $display("FAIL drive_wait: in_rdy=%b after %0d cycles, required 1", in_bus.rdy, cnt);
    end
    in_bus.wr = 1'b1;
    @(posedge clk);
    #1;
    in_bus.wr = 1'b0;
  endtask

  task automatic send_packet(input bit with_ioq, input logic [7:0] pay[$]);
    logic [63:0] d;
    int n, k;
    n = pay.size();
    model_packet(with_ioq, pay);
    if (with_ioq) drive_word(make_ioq(n), IOQ_CTRL);
    for (int w = 0; 8 * w < n; w++) begin
      d = {$urandom, $urandom};
      k = (n - 8 * w > 8) ? 8 : n - 8 * w;
      for (int j = 0; j < k; j++) d[63 - 8 * j -: 8] = pay[8 * w + j];
      drive_word(d, (8 * w + k == n) ? (8'h80 >> (k - 1)) : 8'h00);
    end
  endtask

  task automatic wait_out(input int n);
    int cnt;
    cnt = 0;
    while (act_q.size() < n && cnt < WAIT_LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic rand_payload(input int n, output logic [7:0] pay[$]);
    pay = {};
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_bus.wr !== 1'b0) begin bad++; $display("FAIL reset_out_wr: got %b want 0", out_bus.wr); end
    total++;
    if (out_bus.data !== 64'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_bus.data); end
    total++;
    if (out_bus.ctrl !== 8'h0) begin bad++; $display("FAIL reset_out_ctrl: got %h want 0", out_bus.ctrl); end
    total++;
    if (in_bus.rdy !== 1'b0) begin bad++; $display("FAIL reset_in_rdy: got %b want 0", in_bus.rdy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_bus.rdy !== 1'b1) begin bad++; $display("FAIL idle_in_rdy: got %b want 1", in_bus.rdy); end
    $display("test_reset done");
  endtask

  task automatic test_ioq_len();
    logic [7:0] pay[$];
    exp_q = {};
    act_q = {};
    dst_mac = 48'h0A0B0C0D0E0F;
    src_mac = 48'h102030405060;
    ethertype = 16'h86DD;
    rand_payload(50, pay);
    send_packet(1'b1, pay);
    wait_out(9);
    total++;
    if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL ioq_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      total++;
      if (((act_q[i].d ^ exp_q[i].d) & valid_mask(exp_q[i].c)) !== 64'h0 || act_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL ioq_word%0d: got %h/%h want %h/%h", i, act_q[i].d, act_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    if (act_q.size() > 0) begin
      total++;
`ifdef ETH_HDR_INS_LEN_FIXUP_EN
      if (act_q[0].d[15:0] !== 16'd64 || act_q[0].d[47:32] !== 16'd8) begin
        bad++; $display("FAIL ioq_fields: got len=%0d words=%0d want 64/8", act_q[0].d[15:0], act_q[0].d[47:32]);
      end
`else
      if (act_q[0].d[15:0] !== 16'd50 || act_q[0].d[47:32] !== 16'd7) begin
        bad++; $display("FAIL ioq_fields: got len=%0d words=%0d want 50/7", act_q[0].d[15:0], act_q[0].d[47:32]);
      end
`endif
      total++;
      if (act_q[act_q.size() - 1].c !== 8'h01) begin
        bad++; $display("FAIL ioq_last_ctrl: got %h want 01", act_q[act_q.size() - 1].c);
      end
    end
    $display("test_ioq_len: %0d words seen", act_q.size());
  endtask

  task automatic test_flush();
    logic [7:0] pay[$];
    exp_q = {};
    act_q = {};
    dst_mac = 48'($urandom) << 16 | 48'($urandom);
    src_mac = 48'($urandom) << 16 | 48'($urandom);
    ethertype = 16'h0806;
    rand_payload(16, pay);
    send_packet(1'b0, pay);
    @(negedge clk);
    total++;
    if (in_bus.rdy !== 1'b0) begin bad++; $display("FAIL flush_rdy_low: got %b want 0", in_bus.rdy); end
    @(negedge clk);
    total++;
    if (in_bus.rdy !== 1'b1) begin bad++; $display("FAIL flush_rdy_back: got %b want 1", in_bus.rdy); end
    wait_out(4);
    total++;
    if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL flush_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      total++;
      if (((act_q[i].d ^ exp_q[i].d) & valid_mask(exp_q[i].c)) !== 64'h0 || act_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL flush_word%0d: got %h/%h want %h/%h", i, act_q[i].d, act_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    total++;
    if (act_q.size() == 0 || act_q[act_q.size() - 1].c !== 8'h04) begin
      bad++; $display("FAIL flush_last_ctrl: last ctrl wrong (words=%0d), want 04", act_q.size());
    end
    $display("test_flush: %0d words seen", act_q.size());
  endtask

  task automatic test_single_word();
    exp_q = {};
    act_q = {};
    dst_mac = 48'h001122334455;
    src_mac = 48'hAABBCCDDEEFF;
    ethertype = 16'h0800;
    exp_q.push_back(word_t'{64'h001122334455AABB, 8'h00});
    exp_q.push_back(word_t'{64'hCCDDEEFF08005A00, 8'h02});
    drive_word({8'h5A, 24'($urandom), $urandom}, 8'h80);
    @(negedge clk);
    total++;
    if (in_bus.rdy !== 1'b0) begin bad++; $display("FAIL single_held_rdy: got %b want 0", in_bus.rdy); end
    wait_out(2);
    total++;
    if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL single_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      total++;
      if (((act_q[i].d ^ exp_q[i].d) & valid_mask(exp_q[i].c)) !== 64'h0 || act_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL single_word%0d: got %h/%h want %h/%h", i, act_q[i].d, act_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    $display("test_single_word: %0d words seen", act_q.size());
  endtask

  task automatic test_stall();
    logic [7:0] pay[$];
    exp_q = {};
    act_q = {};
    rdy_violations = 0;
    dst_mac = 48'hDEADBEEF0001;
    src_mac = 48'hCAFEF00D0002;
    ethertype = 16'h88CC;
    rand_payload(37, pay);
    stall_mode = 1'b1;
    send_packet(1'b1, pay);
    wait_out(exp_q.size());
    stall_mode = 1'b0;
    total++;
    if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL stall_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      total++;
      if (((act_q[i].d ^ exp_q[i].d) & valid_mask(exp_q[i].c)) !== 64'h0 || act_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL stall_word%0d: got %h/%h want %h/%h", i, act_q[i].d, act_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    total++;
    if (rdy_violations !== 0) begin bad++; $display("FAIL stall_rdy: %0d writes with out_rdy low, want 0", rdy_violations); end
    $display("test_stall: %0d words seen", act_q.size());
  endtask

  task automatic test_reset_mid();
    logic [7:0] pay[$];
    drive_word(make_ioq(40), IOQ_CTRL);
    for (int i = 0; i < 3; i++) drive_word({$urandom, $urandom}, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_bus.wr !== 1'b0) begin bad++; $display("FAIL midreset_out_wr: got %b want 0", out_bus.wr); end
    act_q = {};
    exp_q = {};
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (act_q.size() !== 0) begin bad++; $display("FAIL midreset_leftover: got %0d words want 0", act_q.size()); end
    dst_mac = 48'h665544332211;
    src_mac = 48'h0F0E0D0C0B0A;
    ethertype = 16'h0800;
    rand_payload(20, pay);
    send_packet(1'b1, pay);
    wait_out(exp_q.size());
    total++;
    if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL midreset_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      total++;
      if (((act_q[i].d ^ exp_q[i].d) & valid_mask(exp_q[i].c)) !== 64'h0 || act_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL midreset_word%0d: got %h/%h want %h/%h", i, act_q[i].d, act_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    $display("test_reset_mid: %0d words seen", act_q.size());
  endtask

  task automatic test_back_to_back();
    logic [7:0] pay[$];
    int n;
    exp_q = {};
    act_q = {};
    rdy_violations = 0;
    for (int p = 0; p < 12; p++) begin
      dst_mac = {16'($urandom), $urandom};
      src_mac = {16'($urandom), $urandom};
      ethertype = 16'($urandom);
      n = $urandom_range(1, 64);
      rand_payload(n, pay);
      stall_mode = ($urandom_range(0, 2) == 0);
      send_packet(1'($urandom), pay);
      $display("back_to_back packet %0d: %0d bytes sent", p, n);
    end
    stall_mode = 1'b0;
    wait_out(exp_q.size());
    total++;
    if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      total++;
      if (((act_q[i].d ^ exp_q[i].d) & valid_mask(exp_q[i].c)) !== 64'h0 || act_q[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL b2b_word%0d: got %h/%h want %h/%h", i, act_q[i].d, act_q[i].c, exp_q[i].d, exp_q[i].c);
      end
    end
    total++;
    if (rdy_violations !== 0) begin bad++; $display("FAIL b2b_rdy: %0d writes with out_rdy low, want 0", rdy_violations); end
  endtask

  initial begin
    in_bus.data = '0;
    in_bus.ctrl = '0;
    in_bus.wr   = 1'b0;
    test_reset();
    test_ioq_len();
    test_flush();
    test_single_word();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
